// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe: 3-stage valid/ready pipelined Vedic multiplier built from a recursive tree of 2x2 cells.
// Define VEDIC_SIGNED_EN to honour in_sgn (two's-complement operands); otherwise all operations are unsigned.
module vedic_cell #(
  parameter int N = 2
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);
  if (N == 2) begin : g_leaf
    logic c1;
    assign p[0] = a[0] & b[0];
    assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
    assign c1   = (a[1] & b[0]) & (a[0] & b[1]);
    assign p[2] = (a[1] & b[1]) ^ c1;
    assign p[3] = (a[1] & b[1]) & c1;
  end else begin : g_node
    localparam int H = N / 2;
    logic [N-1:0] ll, lh, hl, hh;
    logic [N:0]   mid;
    vedic_cell #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
    vedic_cell #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(lh));
    vedic_cell #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(hl));
    vedic_cell #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(hh));
    assign mid = {1'b0, lh} + {1'b0, hl};
    assign p   = {{N{1'b0}}, ll} + {{(H-1){1'b0}}, mid, {H{1'b0}}} + {hh, {N{1'b0}}};
  end
endmodule

module vedic_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_sgn,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag
);
  localparam int H  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;
  if (!(WIDTH == 4 || WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_bad_width
    $error("vedic_mult_pipe: WIDTH must be 4, 8, 16 or 32");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("vedic_mult_pipe: TAG_W must be at least 1");
  end
  logic             en;
  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
  logic [WIDTH-1:0] ll_q, ll_d, lh_q, lh_d, hl_q, hl_d, hh_q, hh_d;
  logic [PW-1:0]    p_q, p_d, sum;
  logic [WIDTH:0]   mid;
  vedic_cell #(.N(H)) u_ll (.a(a1_q[H-1:0]),     .b(b1_q[H-1:0]),     .p(ll_d));
  vedic_cell #(.N(H)) u_lh (.a(a1_q[H-1:0]),     .b(b1_q[WIDTH-1:H]), .p(lh_d));
  vedic_cell #(.N(H)) u_hl (.a(a1_q[WIDTH-1:H]), .b(b1_q[H-1:0]),     .p(hl_d));
  vedic_cell #(.N(H)) u_hh (.a(a1_q[WIDTH-1:H]), .b(b1_q[WIDTH-1:H]), .p(hh_d));
  always_comb begin
    en     = !v3_q | out_ready;
    v1_d   = in_valid;
    tag1_d = in_tag;
    v2_d   = v1_q;
    tag2_d = tag1_q;
    v3_d   = v2_q;
    tag3_d = tag2_q;
    mid    = {1'b0, lh_q} + {1'b0, hl_q};
    sum    = {{WIDTH{1'b0}}, ll_q} + {{(H-1){1'b0}}, mid, {H{1'b0}}} + {hh_q, {WIDTH{1'b0}}};
  end
`ifdef VEDIC_SIGNED_EN
  logic s1_q, s1_d, s2_q, s2_d, na, nb;
  // Magnitudes stay WIDTH-bit unsigned, so the most negative operand maps to itself exactly.
  always_comb begin
    na   = in_sgn & in_a[WIDTH-1];
    nb   = in_sgn & in_b[WIDTH-1];
    a1_d = na ? -in_a : in_a;
    b1_d = nb ? -in_b : in_b;
    s1_d = na ^ nb;
    s2_d = s1_q;
    p_d  = s2_q ? -sum : sum;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else if (en) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
`else
  logic sgn_unused;
  assign sgn_unused = in_sgn;
  always_comb begin
    a1_d = in_a;
    b1_d = in_b;
    p_d  = sum;
  end
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      tag1_q <= '0;
      tag2_q <= '0;
      tag3_q <= '0;
      ll_q   <= '0;
      lh_q   <= '0;
      hl_q   <= '0;
      hh_q   <= '0;
      p_q    <= '0;
    end else if (en) begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      a1_q   <= a1_d;
      b1_q   <= b1_d;
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
      tag3_q <= tag3_d;
      ll_q   <= ll_d;
      lh_q   <= lh_d;
      hl_q   <= hl_d;
      hh_q   <= hh_d;
      p_q    <= p_d;
    end
  assign in_ready  = en;
  assign out_valid = v3_q;
  assign out_p     = p_q;
  assign out_tag   = tag3_q;
endmodule
